// File: rtl/fpu_e2m_ctrl.sv
// E-to-M stage sequencer for the shared iterative divide/sqrt array.
// Stalls the front end while the array runs, then steers its result onto ealu.
module fpu_e2m_ctrl #(
  parameter int unsigned DIV_CYC  = 14,
  parameter int unsigned SQRT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_valid,
  input  logic       e_fdiv,
  input  logic       e_fsqrt,
  input  logic       intr,
  output logic       fu_start,
  output logic       fu_op,
  output logic       fu_abort,
  output logic       stall_e,
  output logic       e2m_bubble,
  output logic       e2m_rsel,
  output logic       busy,
  output logic [4:0] cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYC - 1);
  localparam logic [4:0] SQRT_LAT = 5'(SQRT_CYC - 1);

  state_t     state, state_nxt;
  logic [4:0] cnt_q, cnt_nxt;
  logic       op_q, op_nxt;
  logic       accept;

  assign accept = (state == IDLE) && e_valid && (e_fdiv || e_fsqrt) && !intr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
      op_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    op_nxt    = op_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          // div wins when both opcodes are flagged
          cnt_nxt   = e_fdiv ? DIV_LAT : SQRT_LAT;
          op_nxt    = !e_fdiv;
        end
      end
      RUN: begin
        if (intr || cnt_q == 5'd1) begin
          state_nxt = intr ? IDLE : DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_q - 5'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    fu_start   = 1'b0;
    fu_abort   = 1'b0;
    stall_e    = 1'b0;
    e2m_bubble = 1'b0;
    e2m_rsel   = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          fu_start   = accept;
          stall_e    = accept;
          e2m_bubble = accept;
        end
        RUN: begin
          fu_abort   = intr;
          stall_e    = !intr;
          e2m_bubble = 1'b1;
        end
        DONE: begin
          fu_abort   = intr;
          e2m_bubble = intr;
          e2m_rsel   = !intr;
        end
        default: ;
      endcase
    end
  end

  // Registered values are masked while reset is held so every output reads 0.
  assign cnt   = rst ? '0 : cnt_q;
  assign fu_op = rst ? 1'b0 : op_q;

endmodule

// File: tb/tb_fpu_e2m_ctrl.sv
// Directed bench for fpu_e2m_ctrl: per-cycle vector table plus hand sequences
// for the full-length div/sqrt, back-to-back, interrupt and reset cases.
module tb_fpu_e2m_ctrl;

  logic       clk = 1'b0;
  logic       rst, e_valid, e_fdiv, e_fsqrt, intr;
  logic       fu_start, fu_op, fu_abort, stall_e, e2m_bubble, e2m_rsel, busy;
  logic [4:0] cnt;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  fpu_e2m_ctrl #(.DIV_CYC(14), .SQRT_CYC(16)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_fdiv(e_fdiv), .e_fsqrt(e_fsqrt),
    .intr(intr), .fu_start(fu_start), .fu_op(fu_op), .fu_abort(fu_abort),
    .stall_e(stall_e), .e2m_bubble(e2m_bubble), .e2m_rsel(e2m_rsel),
    .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // {start, op, abort, stall, bubble, rsel, busy, cnt[4:0]}
  typedef struct {
    logic       rst, v, d, s, i;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] pk(input logic st, op, ab, sl, bb, rs, by,
                                     input logic [4:0] c);
    return {st, op, ab, sl, bb, rs, by, c};
  endfunction

  function automatic logic [11:0] outs();
    return {fu_start, fu_op, fu_abort, stall_e, e2m_bubble, e2m_rsel, busy, cnt};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic r, v, d, s, i);
    @(negedge clk);
    rst = r; e_valid = v; e_fdiv = d; e_fsqrt = s; intr = i;
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    logic saw_rsel, saw_abort;
    int unsigned stalls;

    tbl[0]  = '{1,0,0,0,0, pk(0,0,0,0,0,0,0,5'd0)};
    tbl[1]  = '{1,1,1,0,0, pk(0,0,0,0,0,0,0,5'd0)};
    tbl[2]  = '{0,1,1,1,1, pk(0,0,0,0,0,0,0,5'd0)};   // intr blocks accept
    tbl[3]  = '{0,1,1,1,0, pk(1,0,0,1,1,0,0,5'd0)};   // both set -> div accept
    tbl[4]  = '{0,1,0,0,0, pk(0,0,0,1,1,0,1,5'd13)};
    tbl[5]  = '{0,1,0,0,1, pk(0,0,1,0,1,0,1,5'd12)};  // abort in RUN
    tbl[6]  = '{0,0,0,0,0, pk(0,0,0,0,0,0,0,5'd0)};
    tbl[7]  = '{0,1,0,0,0, pk(0,0,0,0,0,0,0,5'd0)};
    tbl[8]  = '{0,0,0,1,0, pk(0,0,0,0,0,0,0,5'd0)};
    tbl[9]  = '{0,1,0,1,0, pk(1,0,0,1,1,0,0,5'd0)};   // sqrt accept
    tbl[10] = '{0,1,0,1,0, pk(0,1,0,1,1,0,1,5'd15)};
    tbl[11] = '{1,1,0,1,0, pk(0,0,0,0,0,0,0,5'd0)};   // reset mid-RUN
    tbl[12] = '{0,0,0,0,0, pk(0,0,0,0,0,0,0,5'd0)};

    rst = 1'b1; e_valid = 1'b0; e_fdiv = 1'b0; e_fsqrt = 1'b0; intr = 1'b0;
    repeat (3) @(posedge clk);

    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].s, tbl[k].i);
      chk($sformatf("vec%0d", k), outs(), tbl[k].exp);
    end

    // fdiv with e_fdiv held through DONE: latency, counter walk, no re-accept in DONE.
    cyc(0,1,1,0,0);
    chk("div_T", outs(), pk(1,0,0,1,1,0,0,5'd0));
    for (int k = 1; k <= 13; k++) begin
      cyc(0,1,1,0,0);
      chk($sformatf("div_T+%0d", k), outs(), pk(0,0,0,1,1,0,1,5'(14-k)));
    end
    cyc(0,1,1,0,0);
    chk("div_done", outs(), pk(0,0,0,0,0,1,1,5'd0));
    cyc(0,1,1,0,0);
    chk("div_b2b_start", outs(), pk(1,0,0,1,1,0,0,5'd0));

    // Second op aborted by intr at T+5.
    saw_rsel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(0,1,1,0,0);
      saw_rsel |= e2m_rsel;
    end
    cyc(0,1,1,0,1);
    chk("intr_T+5", outs(), pk(0,0,1,0,1,0,1,5'd9));
    cyc(0,0,0,0,0);
    chk("intr_T+6", outs(), pk(0,0,0,0,0,0,0,5'd0));
    chk1("intr_no_rsel", saw_rsel, 1'b0);

    // fsqrt: count stall cycles until busy drops, bounded.
    cyc(0,1,0,1,0);
    chk1("sqrt_start", fu_start, 1'b1);
    stalls = stall_e ? 1 : 0;
    for (int k = 0; k < 40 && (busy || k == 0); k++) begin
      cyc(0,1,0,1,0);
      if (busy && !e2m_rsel) chk1($sformatf("sqrt_op%0d", k), fu_op, 1'b1);
      if (stall_e) stalls++;
      if (e2m_rsel) cyc(0,0,0,0,0);
    end
    n_chk++;
    if (stalls != 16) begin
      n_fail++;
      $display("FAIL sqrt_stall_count: got %0d expected 16", stalls);
    end
    chk("sqrt_idle_op_held", outs(), pk(0,1,0,0,0,0,0,5'd0));

    // Reset at T+7: outputs zero that cycle, IDLE afterwards, no abort pulse.
    saw_abort = 1'b0;
    cyc(0,1,1,0,0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0,1,0,0,0);
      saw_abort |= fu_abort;
    end
    cyc(1,1,0,0,0);
    saw_abort |= fu_abort;
    chk("rst_T+7", outs(), pk(0,0,0,0,0,0,0,5'd0));
    cyc(0,0,0,0,0);
    saw_abort |= fu_abort;
    chk("rst_T+8", outs(), pk(0,0,0,0,0,0,0,5'd0));
    chk1("rst_no_abort", saw_abort, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_e2m_ctrl.md
FPU_E2M_CTRL -- requirements
Module: fpu_e2m_ctrl

Interface
REQ-001 Parameter DIV_CYC, default 14: stall cycles for fdiv, legal range 2..31.
REQ-002 Parameter SQRT_CYC, default 16: stall cycles for fsqrt, legal range 2..31.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 e_valid  input  1  EX stage holds a valid instruction.
REQ-006 e_fdiv  input  1  EX instruction is fdiv; needs the shared iterative divide/sqrt array.
REQ-007 e_fsqrt  input  1  EX instruction is fsqrt; same array.
REQ-008 intr  input  1  interrupt taken this cycle; cancels the EX instruction.
REQ-009 fu_start  output  1  one-cycle start pulse to the iterative array.
REQ-010 fu_op  output  1  operation select to the array: 0 div, 1 sqrt; held from start through done.
REQ-011 fu_abort  output  1  one-cycle abort pulse to the array.
REQ-012 stall_e  output  1  freeze PC, F/D and D/E registers.
REQ-013 e2m_bubble  output  1  force ewreg, ewmem, em2reg and ewfpr to 0 at the E/M register input.
REQ-014 e2m_rsel  output  1  select the array result onto ealu.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 cnt  output  5  remaining-cycle counter, for debug.

Function
REQ-017 States SHALL be IDLE, RUN and DONE, held in a registered state variable.
REQ-018 An accept SHALL occur in IDLE when e_valid=1, (e_fdiv|e_fsqrt)=1 and intr=0.
REQ-019 If e_fdiv and e_fsqrt are both 1, the accept SHALL use div (fu_op=0).
REQ-020 In the accept cycle: fu_start=1, stall_e=1, e2m_bubble=1; on the clock edge cnt<=LAT-1 (LAT = DIV_CYC or SQRT_CYC), fu_op latched, state<=RUN.
REQ-021 In RUN: stall_e=1, e2m_bubble=1, cnt decrements each cycle; when cnt==1 on the edge, state<=DONE and cnt<=0.
REQ-022 In DONE: stall_e=0, e2m_bubble=0, e2m_rsel=1; the E/M register loads the result, and state<=IDLE.
REQ-023 The request seen in DONE SHALL NOT be accepted; the next accept is possible no earlier than the following IDLE cycle.
REQ-024 Total stall_e cycles per op SHALL equal LAT exactly; the result SHALL appear in the DONE cycle, LAT cycles after the accept.
REQ-025 intr=1 in RUN or DONE SHALL produce fu_abort=1, stall_e=0, e2m_bubble=1 and e2m_rsel=0 that cycle; on the edge, state<=IDLE and cnt<=0.
REQ-026 intr=1 in IDLE SHALL block any accept; fu_start=0, fu_abort=0, e2m_bubble=0.
REQ-027 In IDLE with no accept, all outputs except fu_op SHALL be 0; fu_op holds its last value.
REQ-028 stall_e, e2m_bubble, e2m_rsel, fu_start and fu_abort are decoded from state, cnt and the current-cycle inputs; no output depends on intr except as stated in REQ-025 and REQ-026.
REQ-029 e_fdiv and e_fsqrt are ignored outside IDLE; the EX instruction is frozen while stalled.

Reset
REQ-030 rst=1 at a clock edge SHALL set state=IDLE, cnt=0, fu_op=0; this takes priority over all other updates.
REQ-031 While rst=1, fu_start, fu_abort, stall_e, e2m_bubble, e2m_rsel and busy SHALL all be 0.
REQ-032 rst asserted mid-RUN SHALL abandon the op without pulsing fu_abort; the first cycle after rst deasserts is IDLE.

Verification
REQ-033 fdiv accepted at cycle T with DIV_CYC=14 -> fu_start at T; stall_e T..T+13; cnt 13..1 over T+1..T+13; DONE with e2m_rsel=1 at T+14; busy=0 at T+15.
REQ-034 fsqrt with SQRT_CYC=16 -> stall_e asserted 16 cycles; fu_op=1 from T+1 until the next accept.
REQ-035 Back-to-back fdiv with e_fdiv held high through DONE -> second fu_start at T+15, not T+14.
REQ-036 intr at T+5 of an fdiv -> fu_abort=1, e2m_bubble=1, stall_e=0 at T+5; IDLE and cnt=0 at T+6; no e2m_rsel pulse.
REQ-037 Simultaneous e_fdiv=1, e_fsqrt=1 and intr=1 in IDLE -> no fu_start; next cycle with intr=0 -> accept with fu_op=0.
REQ-038 rst=1 at T+7 of an op -> all outputs 0 from T+7; state IDLE and cnt=0 after the edge; fu_abort never asserted.
